decode_stage: RTL and testbench

Instruction-decode stage of the pipelined core, between the IF/ID register and execute. It decodes the instruction and drives the register-file read addresses, including the CSR index for CSRRS. It forwards results from EX and MEM, detects load-use hazards and produces the registered ID/EX bundle. A bubble on that bundle is the signal that later gates retirement counting in the register file.

---
 rtl/decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_decode_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction decode, EX/MEM operand forwarding, load-use stall and the ID/EX register.
module decode_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [4:0]      rf_rs1_o,
  output logic [4:0]      rf_rs2_o,
  output logic [11:0]     rf_csr_o,
  output logic            rf_csrrs_o,
  input  logic [XLEN-1:0] rf_data1_i,
  input  logic [XLEN-1:0] rf_data2_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_we_i,
  input  logic            ex_is_load_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic [4:0]      mem_rd_i,
  input  logic            mem_we_i,
  input  logic [XLEN-1:0] mem_result_i,
  output logic            id_bubble_o,
  output logic [6:0]      id_opcode_o,
  output logic [2:0]      id_funct3_o,
  output logic [6:0]      id_funct7_o,
  output logic [4:0]      id_rd_o,
  output logic            id_we_o,
  output logic            id_csrrs_o,
  output logic [11:0]     id_csr_o,
  output logic [XLEN-1:0] id_op1_o,
  output logic [XLEN-1:0] id_op2_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [PC_W-1:0] id_pc_o
);
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            is_csrrs, i_type, u_type, writes_rd, use_rs1, use_rs2;
  logic            live_rs1, live_rs2, haz_rs1, haz_rs2, load_en;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm, op1, op2;

  logic            bubble_q, bubble_d, we_q, we_d, csrrs_q, csrrs_d;
  logic [6:0]      opcode_q, opcode_d, funct7_q, funct7_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d;
  logic [11:0]     csr_q, csr_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [PC_W-1:0] pc_q, pc_d;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  assign is_csrrs = opcode == OPC_SYSTEM && funct3 == 3'b010;
  assign i_type   = opcode == OPC_LOAD || opcode == OPC_OP_IMM || opcode == OPC_OP_IMM_32 ||
                    opcode == OPC_JALR || opcode == OPC_SYSTEM;
  assign u_type   = opcode == OPC_LUI || opcode == OPC_AUIPC;

  always_comb begin
    imm32 = i_type                ? {{20{instr_i[31]}}, instr_i[31:20]} :
            opcode == OPC_STORE   ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
            opcode == OPC_BRANCH  ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                                     instr_i[11:8], 1'b0} :
            u_type                ? {instr_i[31:12], 12'b0} :
            opcode == OPC_JAL     ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                                     instr_i[30:21], 1'b0} :
                                    32'b0;
  end

  assign imm = {{(XLEN-32){imm32[31]}}, imm32};

  assign writes_rd = rd != 5'd0 &&
                     (opcode == OPC_OP || opcode == OPC_OP_32 || opcode == OPC_OP_IMM ||
                      opcode == OPC_OP_IMM_32 || opcode == OPC_LOAD || opcode == OPC_LUI ||
                      opcode == OPC_AUIPC || opcode == OPC_JAL || opcode == OPC_JALR || is_csrrs);

  assign use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  // On CSRRS the rs2 field is part of the CSR index and data2 carries the CSR value.
  assign use_rs2 = (opcode == OPC_OP || opcode == OPC_OP_32 || opcode == OPC_STORE ||
                    opcode == OPC_BRANCH) && !is_csrrs;

  assign live_rs1 = use_rs1 && rs1 != 5'd0;
  assign live_rs2 = use_rs2 && rs2 != 5'd0;

  assign op1 = live_rs1 && ex_we_i && !ex_is_load_i && ex_rd_i == rs1 ? ex_result_i :
               live_rs1 && mem_we_i && mem_rd_i == rs1                ? mem_result_i :
                                                                        rf_data1_i;
  assign op2 = live_rs2 && ex_we_i && !ex_is_load_i && ex_rd_i == rs2 ? ex_result_i :
               live_rs2 && mem_we_i && mem_rd_i == rs2                ? mem_result_i :
                                                                        rf_data2_i;

  assign haz_rs1 = live_rs1 && ex_rd_i == rs1;
  assign haz_rs2 = live_rs2 && ex_rd_i == rs2;
  assign stall_o = instr_valid_i && !flush_i && ex_we_i && ex_is_load_i && (haz_rs1 || haz_rs2);
  assign load_en = instr_valid_i && !flush_i && !stall_o;

  assign rf_rs1_o   = rs1;
  assign rf_rs2_o   = rs2;
  assign rf_csr_o   = instr_i[31:20];
  assign rf_csrrs_o = is_csrrs;

  // Only the control bits that matter downstream are cleared on a bubble.
  always_comb begin
    bubble_d = !load_en;
    we_d     = load_en && writes_rd;
    csrrs_d  = load_en && is_csrrs;
    opcode_d = opcode;
    funct3_d = funct3;
    funct7_d = funct7;
    rd_d     = rd;
    csr_d    = instr_i[31:20];
    op1_d    = op1;
    op2_d    = op2;
    imm_d    = imm;
    pc_d     = pc_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= 1'b1;
      we_q     <= 1'b0;
      csrrs_q  <= 1'b0;
      opcode_q <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      rd_q     <= '0;
      csr_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
    end else begin
      bubble_q <= bubble_d;
      we_q     <= we_d;
      csrrs_q  <= csrrs_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      rd_q     <= rd_d;
      csr_q    <= csr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
    end
  end

  assign id_bubble_o = bubble_q;
  assign id_we_o     = we_q;
  assign id_csrrs_o  = csrrs_q;
  assign id_opcode_o = opcode_q;
  assign id_funct3_o = funct3_q;
  assign id_funct7_o = funct7_q;
  assign id_rd_o     = rd_q;
  assign id_csr_o    = csr_q;
  assign id_op1_o    = op1_q;
  assign id_op2_o    = op2_q;
  assign id_imm_o    = imm_q;
  assign id_pc_o     = pc_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized checks of decode_stage against a behavioural model.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset, instr_valid_i, flush_i, stall_o, rf_csrrs_o;
  logic [31:0] instr_i;
  logic [63:0] pc_i, rf_data1_i, rf_data2_i, ex_result_i, mem_result_i;
  logic [4:0]  rf_rs1_o, rf_rs2_o, ex_rd_i, mem_rd_i, id_rd_o;
  logic [11:0] rf_csr_o, id_csr_o;
  logic        ex_we_i, ex_is_load_i, mem_we_i;
  logic        id_bubble_o, id_we_o, id_csrrs_o;
  logic [6:0]  id_opcode_o, id_funct7_o;
  logic [2:0]  id_funct3_o;
  logic [63:0] id_op1_o, id_op2_o, id_imm_o, id_pc_o;

  int errors = 0;
  int checks = 0;

  logic        e_bub, e_we, e_csrrs, e_all;
  logic [6:0]  e_opc, e_f7;
  logic [2:0]  e_f3;
  logic [4:0]  e_rd;
  logic [11:0] e_csr;
  logic [63:0] e_op1, e_op2, e_imm, e_pc;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .PC_W(64)) dut (
    .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .instr_i(instr_i), .pc_i(pc_i),
    .flush_i(flush_i), .stall_o(stall_o), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .rf_csr_o(rf_csr_o), .rf_csrrs_o(rf_csrrs_o), .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i),
    .ex_rd_i(ex_rd_i), .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i), .ex_result_i(ex_result_i),
    .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i), .mem_result_i(mem_result_i),
    .id_bubble_o(id_bubble_o), .id_opcode_o(id_opcode_o), .id_funct3_o(id_funct3_o),
    .id_funct7_o(id_funct7_o), .id_rd_o(id_rd_o), .id_we_o(id_we_o), .id_csrrs_o(id_csrrs_o),
    .id_csr_o(id_csr_o), .id_op1_o(id_op1_o), .id_op2_o(id_op2_o), .id_imm_o(id_imm_o),
    .id_pc_o(id_pc_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] o);
    return {f7, s2, s1, f3, d, o};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] o);
    return {im, s1, f3, d, o};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2, input logic [4:0] s1);
    return {im[12], im[10:5], s2, s1, 3'b000, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6f};
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] i);
    longint v;
    case (i[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67, 7'h73: v = longint'($signed(i[31:20]));
      7'h23: v = longint'($signed({i[31:25], i[11:7]}));
      7'h63: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      7'h37, 7'h17: v = longint'($signed(i[31:12])) * 4096;
      7'h6f: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit ref_writes(input logic [31:0] i);
    bit w;
    w = i[6:0] inside {7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67} ||
        (i[6:0] == 7'h73 && i[14:12] == 3'd2);
    return w && i[11:7] != 5'd0;
  endfunction

  function automatic logic [63:0] ref_operand(input logic [4:0] s, input bit used, input logic [63:0] rf);
    if (!used || s == 5'd0) return rf;
    if (ex_we_i && !ex_is_load_i && ex_rd_i == s) return ex_result_i;
    if (mem_we_i && mem_rd_i == s) return mem_result_i;
    return rf;
  endfunction

  task automatic cycle();
    logic [31:0] i;
    bit cs, u1, u2, stl, ld;
    #1;
    i   = instr_i;
    cs  = i[6:0] == 7'h73 && i[14:12] == 3'd2;
    u1  = !(i[6:0] inside {7'h37, 7'h17, 7'h6f});
    u2  = i[6:0] inside {7'h33, 7'h3b, 7'h23, 7'h63} && !cs;
    stl = instr_valid_i && !flush_i && ex_we_i && ex_is_load_i &&
          ((u1 && i[19:15] != 0 && ex_rd_i == i[19:15]) || (u2 && i[24:20] != 0 && ex_rd_i == i[24:20]));
    check("stall", stall_o, stl);
    check("rf_rs1", rf_rs1_o, i[19:15]);
    check("rf_rs2", rf_rs2_o, i[24:20]);
    check("rf_csr", rf_csr_o, i[31:20]);
    check("rf_csrrs", rf_csrrs_o, cs);
    ld    = instr_valid_i && !flush_i && !stl;
    e_all = reset;
    if (reset) begin
      {e_bub, e_we, e_csrrs} = 3'b100;
      {e_opc, e_f7, e_f3, e_rd, e_csr} = '0;
      {e_op1, e_op2, e_imm, e_pc} = '0;
    end else if (ld) begin
      e_bub = 0; e_we = ref_writes(i); e_csrrs = cs;
      e_opc = i[6:0]; e_f3 = i[14:12]; e_f7 = i[31:25]; e_rd = i[11:7]; e_csr = i[31:20];
      e_op1 = ref_operand(i[19:15], u1, rf_data1_i);
      e_op2 = ref_operand(i[24:20], u2, rf_data2_i);
      e_imm = ref_imm(i); e_pc = pc_i;
    end else begin
      {e_bub, e_we, e_csrrs} = 3'b100;
    end
    @(posedge clk);
    #1;
    check("id_bubble", id_bubble_o, e_bub);
    check("id_we", id_we_o, e_we);
    check("id_csrrs", id_csrrs_o, e_csrrs);
    if (e_all || !e_bub) begin
      check("id_opcode", id_opcode_o, e_opc);
      check("id_funct3", id_funct3_o, e_f3);
      check("id_funct7", id_funct7_o, e_f7);
      check("id_rd", id_rd_o, e_rd);
      check("id_csr", id_csr_o, e_csr);
      check("id_op1", id_op1_o, e_op1);
      check("id_op2", id_op2_o, e_op2);
      check("id_imm", id_imm_o, e_imm);
      check("id_pc", id_pc_o, e_pc);
    end
  endtask

  initial begin
    logic [6:0] opcs [12] = '{7'h03, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33, 7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73};
    logic [31:0] r;
    int k;
    reset = 1; instr_valid_i = 1; flush_i = 0; pc_i = 64'h1000;
    instr_i = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    rf_data1_i = 64'h11; rf_data2_i = 64'h22;
    ex_rd_i = 0; ex_we_i = 0; ex_is_load_i = 0; ex_result_i = 0;
    mem_rd_i = 0; mem_we_i = 0; mem_result_i = 0;
    cycle(); cycle();
    check("reset_bubble", id_bubble_o, 1);
    check("reset_imm", id_imm_o, 0);
    reset = 0;
    cycle();
    check("addi_imm", id_imm_o, 64'd5);
    check("addi_we", id_we_o, 1);
    check("addi_bubble", id_bubble_o, 0);

    instr_i = enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4, 7'h33);
    ex_we_i = 1; ex_rd_i = 3; ex_result_i = 64'hAA;
    cycle();
    check("exfwd_op1", id_op1_o, 64'hAA);
    check("exfwd_op2", id_op2_o, 64'hAA);
    mem_we_i = 1; mem_rd_i = 3; mem_result_i = 64'hBB;
    cycle();
    check("exwins_op1", id_op1_o, 64'hAA);
    check("exwins_op2", id_op2_o, 64'hAA);

    instr_i = enc_r(7'h20, 5'd1, 5'd5, 3'd0, 5'd6, 7'h33);
    ex_is_load_i = 1; ex_rd_i = 5; mem_we_i = 0;
    #1;
    check("lu_stall", stall_o, 1);
    cycle();
    check("lu_bubble", id_bubble_o, 1);
    ex_we_i = 0; ex_is_load_i = 0; mem_we_i = 1; mem_rd_i = 5; mem_result_i = 64'h1234;
    cycle();
    check("lu_op1", id_op1_o, 64'h1234);
    check("lu_nobubble", id_bubble_o, 0);

    instr_i = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4, 7'h33);
    ex_we_i = 1; ex_rd_i = 0; ex_result_i = 64'hAA; mem_we_i = 0;
    cycle();
    check("x0_op1", id_op1_o, 64'h11);
    instr_i = enc_i(12'hB02, 5'd0, 3'd2, 5'd7, 7'h73);
    ex_rd_i = 2; ex_is_load_i = 1; rf_data2_i = 64'h55;
    #1;
    check("csr_stall", stall_o, 0);
    check("csr_idx", rf_csr_o, 12'hB02);
    check("csr_flag", rf_csrrs_o, 1);
    cycle();
    check("csr_op2", id_op2_o, 64'h55);
    check("csr_we", id_we_o, 1);
    ex_we_i = 0; ex_is_load_i = 0;

    instr_i = enc_b(13'h1FF8, 5'd2, 5'd1);
    cycle();
    check("beq_imm", id_imm_o, 64'hFFFF_FFFF_FFFF_FFF8);
    instr_i = enc_j(21'h800, 5'd1);
    cycle();
    check("jal_imm", id_imm_o, 64'h800);
    instr_i = {20'h80000, 5'd2, 7'h37};
    cycle();
    check("lui_imm", id_imm_o, 64'hFFFF_FFFF_8000_0000);

    instr_i = enc_r(7'h20, 5'd1, 5'd5, 3'd0, 5'd6, 7'h33);
    ex_we_i = 1; ex_is_load_i = 1; ex_rd_i = 5; flush_i = 1;
    #1;
    check("flush_stall", stall_o, 0);
    cycle();
    check("flush_bubble", id_bubble_o, 1);
    flush_i = 0;
    instr_i = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13); ex_we_i = 0; reset = 1;
    cycle();
    check("midreset_bubble", id_bubble_o, 1);
    reset = 0;

    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 12);
      r = $urandom;
      r[6:0] = (k == 12) ? 7'($urandom) : opcs[k];
      r[11:7] = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      if (r[6:0] == 7'h73 && $urandom_range(0, 1) == 1) r[14:12] = 3'd2;
      instr_i = r;
      pc_i = {$urandom, $urandom};
      reset = $urandom_range(0, 49) == 0;
      instr_valid_i = $urandom_range(0, 9) < 9;
      flush_i = $urandom_range(0, 9) == 0;
      rf_data1_i = {$urandom, $urandom}; rf_data2_i = {$urandom, $urandom};
      ex_rd_i = 5'($urandom_range(0, 7)); ex_we_i = 1'($urandom); ex_is_load_i = 1'($urandom);
      ex_result_i = {$urandom, $urandom};
      mem_rd_i = 5'($urandom_range(0, 7)); mem_we_i = 1'($urandom);
      mem_result_i = {$urandom, $urandom};
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
